ysyx_24120013_ifu_fetch: RTL and testbench

YSYX_24120013_IFU_FETCH -- requirements
Module: ysyx_24120013_ifu_fetch

---
 rtl/ysyx_24120013_ifu_fetch.sv | 132 +++++++++++++
 tb/tb_ysyx_24120013_ifu_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24120013_ifu_fetch.sv
// Instruction fetch unit: issues one fetch at a time, holds the returned word
// for decode, and follows redirects from execute. Sticky fault until reset.
`timescale 1ns/1ps
module ysyx_24120013_ifu_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
  input  logic                  ifu_rsp_err,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  IFU_valid,
  input  logic                  IDU_ready,
  output logic [31:0]           IFU_inst,
  output logic [ADDR_WIDTH-1:0] IFU_pc,
  output logic                  IFU_fault,
  output logic [31:0]           IFU_fetch_cnt
);

  // state   | meaning
  // S_IDLE  | just out of reset, no request yet
  // S_REQ   | request presented at pc, waiting for ifu_req_ready
  // S_WAIT  | request accepted, waiting for the response
  // S_HOLD  | instruction held for decode until IDU_ready
  // S_FAULT | misaligned redirect or bus error; only reset leaves
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  drop;
  logic                  redirect_bad;

  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Outputs decode the state register directly, so they change only on clock edges.
  assign ifu_req_valid = (state == S_REQ);
  assign ifu_req_addr  = pc;
  assign ifu_rsp_ready = (state == S_WAIT);
  assign IFU_valid     = (state == S_HOLD);
  assign IFU_fault     = (state == S_FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      drop          <= 1'b0;
      IFU_inst      <= 32'h0;
      IFU_pc        <= RESET_PC;
      IFU_fetch_cnt <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_bad) begin
            IFU_pc <= redirect_pc;
            state  <= S_FAULT;
          end else begin
            if (redirect_valid) pc <= redirect_pc;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect_bad) begin
            IFU_pc <= redirect_pc;
            state  <= S_FAULT;
          end else if (redirect_valid) begin
            pc <= redirect_pc;
            // The old address was already accepted: its response must be discarded.
            if (ifu_req_ready) begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end
          end else if (ifu_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_bad) begin
            IFU_pc <= redirect_pc;
            state  <= S_FAULT;
          end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (ifu_rsp_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (ifu_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              IFU_inst <= ifu_rsp_data[31:0];
              IFU_pc   <= pc;
              state    <= ifu_rsp_err ? S_FAULT : S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_bad) begin
            IFU_pc <= redirect_pc;
            state  <= S_FAULT;
          end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_REQ;
          end else if (IDU_ready) begin
            pc            <= pc + ADDR_WIDTH'(4);
            IFU_fetch_cnt <= IFU_fetch_cnt + 32'd1;
            state         <= S_REQ;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24120013_ifu_fetch.sv
// Directed bench for the fetch unit: inputs change and outputs are checked on
// the falling edge, half a cycle away from the rising edge the DUT uses.
`timescale 1ns/1ps
module tb_ysyx_24120013_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        IFU_valid;
  logic        IDU_ready;
  logic [31:0] IFU_inst;
  logic [31:0] IFU_pc;
  logic        IFU_fault;
  logic [31:0] IFU_fetch_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ysyx_24120013_ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .IFU_valid     (IFU_valid),
    .IDU_ready     (IDU_ready),
    .IFU_inst      (IFU_inst),
    .IFU_pc        (IFU_pc),
    .IFU_fault     (IFU_fault),
    .IFU_fetch_cnt (IFU_fetch_cnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // From REQ: memory accepts now, responds on the next cycle; ends in HOLD or FAULT.
  task automatic fetch(input logic [31:0] data, input logic err);
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = data;
    ifu_rsp_err   = err;
    tick();
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
  endtask

  task automatic consume();
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = 32'h0;
    ifu_rsp_err   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    IDU_ready      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values; a stray response during reset is not accepted.
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'hbad0_bad0;
    #1;
    check("rst_req_valid", ifu_req_valid, 0);
    check("rst_rsp_ready", ifu_rsp_ready, 0);
    check("rst_ifu_valid", IFU_valid, 0);
    check("rst_fault", IFU_fault, 0);
    check("rst_inst", IFU_inst, 0);
    check("rst_pc", IFU_pc, 32'h8000_0000);
    check("rst_cnt", IFU_fetch_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    ifu_rsp_valid = 1'b0;
    check("idle_req_valid", ifu_req_valid, 0);
    tick();

    // First request in the second cycle after release.
    check("first_req_valid", ifu_req_valid, 1);
    check("first_req_addr", ifu_req_addr, 32'h8000_0000);
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    check("wait_rsp_ready", ifu_rsp_ready, 1);
    check("wait_req_valid", ifu_req_valid, 0);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0010_0093;
    tick();
    ifu_rsp_valid = 1'b0;
    check("f0_valid", IFU_valid, 1);
    check("f0_inst", IFU_inst, 32'h0010_0093);
    check("f0_pc", IFU_pc, 32'h8000_0000);

    // Decode stalls for five cycles: everything holds still.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", IFU_valid, 1);
      check("stall_inst", IFU_inst, 32'h0010_0093);
      check("stall_pc", IFU_pc, 32'h8000_0000);
      check("stall_req_valid", ifu_req_valid, 0);
      check("stall_cnt", IFU_fetch_cnt, 0);
    end
    consume();
    check("f1_addr", ifu_req_addr, 32'h8000_0004);
    check("f1_cnt", IFU_fetch_cnt, 1);
    fetch(32'h0020_0113, 1'b0);
    check("f1_inst", IFU_inst, 32'h0020_0113);
    check("f1_pc", IFU_pc, 32'h8000_0004);
    consume();
    check("f2_addr", ifu_req_addr, 32'h8000_0008);
    fetch(32'h0030_0193, 1'b0);
    check("f2_pc", IFU_pc, 32'h8000_0008);
    consume();
    check("f3_cnt", IFU_fetch_cnt, 3);

    // Address stays stable while memory is not ready.
    tick();
    tick();
    check("stable_valid", ifu_req_valid, 1);
    check("stable_addr", ifu_req_addr, 32'h8000_000c);

    // Redirect while waiting: the pending response is thrown away.
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    redirect(32'h8000_0100);
    check("drop_rsp_ready", ifu_rsp_ready, 1);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'hdead_beef;
    tick();
    ifu_rsp_valid = 1'b0;
    check("drop_ifu_valid", IFU_valid, 0);
    check("drop_req_valid", ifu_req_valid, 1);
    check("drop_addr", ifu_req_addr, 32'h8000_0100);
    check("drop_inst", IFU_inst, 32'h0030_0193);
    check("drop_cnt", IFU_fetch_cnt, 3);

    // Redirect in REQ without ready: retarget in place.
    redirect(32'h8000_0200);
    check("req_redir_valid", ifu_req_valid, 1);
    check("req_redir_addr", ifu_req_addr, 32'h8000_0200);

    // Redirect beats a simultaneous IDU_ready in HOLD.
    fetch(32'h1111_1111, 1'b0);
    check("hold_valid", IFU_valid, 1);
    IDU_ready = 1'b1;
    redirect(32'h8000_0300);
    IDU_ready = 1'b0;
    check("hold_redir_valid", IFU_valid, 0);
    check("hold_redir_addr", ifu_req_addr, 32'h8000_0300);
    check("hold_redir_cnt", IFU_fetch_cnt, 3);

    // Bus error at 8000_0008, then a misaligned redirect is ignored.
    redirect(32'h8000_0008);
    fetch(32'h0, 1'b1);
    check("err_fault", IFU_fault, 1);
    check("err_pc", IFU_pc, 32'h8000_0008);
    check("err_ifu_valid", IFU_valid, 0);
    check("err_rsp_ready", ifu_rsp_ready, 0);
    redirect(32'h8000_0002);
    ifu_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fault_req_valid", ifu_req_valid, 0);
    end
    ifu_req_ready = 1'b0;
    check("fault_pc", IFU_pc, 32'h8000_0008);
    check("fault_sticky", IFU_fault, 1);

    // Reset clears the fault asynchronously.
    #1 rst = 1'b0;
    #1;
    check("rst2_fault", IFU_fault, 0);
    check("rst2_inst", IFU_inst, 0);
    check("rst2_cnt", IFU_fetch_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // PC wraps past the top of the address space.
    redirect(32'hffff_fffc);
    fetch(32'h0000_0013, 1'b0);
    check("wrap_pc", IFU_pc, 32'hffff_fffc);
    consume();
    check("wrap_addr", ifu_req_addr, 32'h0000_0000);
    check("wrap_cnt", IFU_fetch_cnt, 1);

    // Redirect coincident with the response.
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h2222_2222;
    redirect(32'h8000_0500);
    ifu_rsp_valid = 1'b0;
    check("coinc_ifu_valid", IFU_valid, 0);
    check("coinc_addr", ifu_req_addr, 32'h8000_0500);
    check("coinc_inst", IFU_inst, 32'h0000_0013);

    // Misaligned redirect faults and records the target.
    redirect(32'h8000_0402);
    check("mis_fault", IFU_fault, 1);
    check("mis_pc", IFU_pc, 32'h8000_0402);
    check("mis_req_valid", ifu_req_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
